// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter in front of a single-port synchronous memory.
//   m0 : instruction-fetch master, reads only.
//   m1 : load/store master, reads and writes, may lock the bus for atomics.
//
// m1 wins by default. A starvation counter tracks consecutive m1 grants
// while m0 waits; once it reaches STARVE_LIMIT, m0 is granted instead,
// unless m1 holds the bus lock.
//
// Handshake: a master raises req and holds req/addr/we/wdata/lock stable
// until the cycle in which its gnt is 1. gnt is combinational, and that
// cycle is the transfer cycle. For reads, mX_rvalid/mX_rdata follow exactly
// one cycle later. Writes complete in the grant cycle with no response.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_req/m0_addr           fetch request
//   m0_gnt/m0_rvalid/m0_rdata fetch grant and read response
//   m1_req/m1_we/m1_addr/m1_wdata/m1_lock  load/store request
//   m1_gnt/m1_rvalid/m1_rdata load/store grant and load response
//   s_en/s_we/s_addr/s_wdata memory command (driven by the granted master)
//   s_rdata                  memory read data, one cycle after a read command
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          s_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata
);

    localparam int            CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          lock_held_q, lock_held_d;
    logic          resp_pending_q, resp_pending_d;
    logic          resp_owner_q, resp_owner_d;   // 0 = m0, 1 = m1
    logic          starved;

    // ------------------------------------------------------------------
    // Grant decision. m0 is blocked outright while the lock register is
    // set; this includes the cycle in which m1_lock drops, because the
    // register only clears at the end of that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        starved = (starve_cnt_q == LIMIT);
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        if (!rst) begin
            if (m0_req && !lock_held_q && (!m1_req || starved)) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory command mux: zero when idle so the bus is quiet.
    // ------------------------------------------------------------------
    assign s_en = m0_gnt | m1_gnt;
    assign s_we = m1_gnt & m1_we;

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        if (m1_gnt) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end else if (m0_gnt) begin
            s_addr  = m0_addr;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Starvation count is frozen while the lock is held, so an atomic
        // sequence neither earns nor forfeits m0's fairness credit.
        starve_cnt_d = starve_cnt_q;
        if (!lock_held_q) begin
            if (!m0_req || m0_gnt) begin
                starve_cnt_d = '0;
            end else if (m1_gnt && !starved) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end

        lock_held_d = lock_held_q;
        if (!m1_lock) begin
            lock_held_d = 1'b0;
        end else if (m1_gnt) begin
            lock_held_d = 1'b1;
        end

        // Only reads produce a response, one cycle after their grant.
        resp_pending_d = m0_gnt | (m1_gnt & ~m1_we);
        resp_owner_d   = resp_owner_q;
        if (s_en) begin
            resp_owner_d = m1_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q   <= '0;
            lock_held_q    <= 1'b0;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            lock_held_q    <= lock_held_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing: data reaches only the owner of the pending read.
    // ------------------------------------------------------------------
    assign m0_rvalid = resp_pending_q & ~resp_owner_q;
    assign m1_rvalid = resp_pending_q &  resp_owner_q;
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule
